econet_rx_deframer: RTL and testbench

- Receive-side HDLC deframer for the Econet bridge CPLD.
- Sits between the line receivers (econet_clock_R, econet_data_R) and the MCU-bound serial transmitter.
- Samples line data on econet clock rising edges, detects flags and aborts, removes stuffed zeros, and assembles bytes LSB-first.
- Presents each byte or flag as a 9-bit word on a valid/ready handshake, using the same 9-bit convention the MCU uses for transmit: bit 8 = 1 means flag.

---
 rtl/econet_rx_deframer.sv | 159 +++++++++++++++
 tb/tb_econet_rx_deframer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/econet_rx_deframer.sv
// Receive-side HDLC deframer: synchronises the Econet line, strips flags, aborts
// and stuffed zeros, and hands bytes/flags to the MCU path as 9-bit words.
module econet_rx_deframer #(
    parameter int SYNC_STAGES           = 2,
    parameter bit SUPPRESS_REPEAT_FLAGS = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic       econet_clock_R,
    input  logic       econet_data_R,
    output logic [8:0] rx_word,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_active,
    output logic       overrun,
    output logic       abort_seen
);
    localparam logic [0:0] HUNT      = 1'b0;
    localparam logic [0:0] FRAME     = 1'b1;
    localparam logic [8:0] FLAG_WORD = 9'h17E;

    logic [SYNC_STAGES-1:0] csync_q, dsync_q;
    logic       cprev_q, ev_q, evbit_q;
    logic [0:0] state_q, state_d;
    logic [2:0] ones_q, ones_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       last_flag_q, last_flag_d;
    logic [8:0] word_q, word_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    logic       abort_q, abort_d;
    logic       emit;
    logic [8:0] emit_word;

    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        last_flag_d = last_flag_q;
        abort_d     = 1'b0;
        emit        = 1'b0;
        emit_word   = FLAG_WORD;
        if (ev_q) begin
            if (evbit_q) begin
                if (ones_q != 3'd7)
                    ones_d = ones_q + 3'd1;
                if (ones_q == 3'd6) begin
                    abort_d     = 1'b1;
                    state_d     = HUNT;
                    bitcnt_d    = 3'd0;
                    last_flag_d = 1'b0;
                end else if (state_q == FRAME && ones_q != 3'd7) begin
                    shreg_d = {1'b1, shreg_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        bitcnt_d    = 3'd0;
                        emit        = 1'b1;
                        emit_word   = {1'b0, shreg_d};
                        last_flag_d = 1'b0;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end else begin
                ones_d = 3'd0;
                if (ones_q == 3'd6) begin
                    state_d     = FRAME;
                    bitcnt_d    = 3'd0;
                    emit        = !(SUPPRESS_REPEAT_FLAGS && last_flag_q);
                    last_flag_d = 1'b1;
                end else if (state_q == FRAME && ones_q != 3'd5) begin
                    // a zero after five ones is a stuffed bit and never reaches the byte
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        bitcnt_d    = 3'd0;
                        emit        = 1'b1;
                        emit_word   = {1'b0, shreg_d};
                        last_flag_d = 1'b0;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
        end
    end

    // Single-entry output buffer: a word arriving while the previous one is unconsumed is dropped.
    always_comb begin
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (emit) begin
            if (!valid_q || rx_ready) begin
                word_d  = emit_word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csync_q     <= '1;
            dsync_q     <= '1;
            cprev_q     <= 1'b1;
            ev_q        <= 1'b0;
            evbit_q     <= 1'b0;
            state_q     <= HUNT;
            ones_q      <= 3'd0;
            bitcnt_q    <= 3'd0;
            last_flag_q <= 1'b0;
            word_q      <= 9'd0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            csync_q <= {csync_q[SYNC_STAGES-2:0], econet_clock_R};
            dsync_q <= {dsync_q[SYNC_STAGES-2:0], econet_data_R};
            cprev_q <= csync_q[SYNC_STAGES-1];
            // the bit event is registered once more before use, fixing latency at SYNC_STAGES+2
            ev_q    <= csync_q[SYNC_STAGES-1] & ~cprev_q;
            evbit_q <= dsync_q[SYNC_STAGES-1];
            if (!rx_enable) begin
                state_q     <= HUNT;
                ones_q      <= 3'd0;
                bitcnt_q    <= 3'd0;
                last_flag_q <= 1'b0;
                valid_q     <= 1'b0;
                overrun_q   <= 1'b0;
                abort_q     <= 1'b0;
            end else begin
                state_q     <= state_d;
                ones_q      <= ones_d;
                bitcnt_q    <= bitcnt_d;
                last_flag_q <= last_flag_d;
                word_q      <= word_d;
                valid_q     <= valid_d;
                overrun_q   <= overrun_d;
                abort_q     <= abort_d;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rx_enable)
            shreg_q <= shreg_d;
    end

    assign rx_word      = word_q;
    assign rx_valid     = valid_q;
    assign frame_active = (state_q == FRAME);
    assign overrun      = overrun_q;
    assign abort_seen   = abort_q;
endmodule

// File: tb/tb_econet_rx_deframer.sv
// Bench for econet_rx_deframer: two instances (repeat-flag suppression on and off)
// share one line; a bit-level model predicts words, aborts and frame state per cycle.
`timescale 1ns/1ps
module tb_econet_rx_deframer;
    localparam int SYNC = 2;

    logic       clock, reset, rx_enable, econet_clock_R, econet_data_R;
    logic       rdy0, rdy1;
    logic [8:0] w0, w1;
    logic       v0, v1, fa0, fa1, ov0, ov1, ab0, ab1;

    econet_rx_deframer #(.SYNC_STAGES(SYNC), .SUPPRESS_REPEAT_FLAGS(1'b0)) dut0 (
        .clock(clock), .reset(reset), .rx_enable(rx_enable),
        .econet_clock_R(econet_clock_R), .econet_data_R(econet_data_R),
        .rx_word(w0), .rx_valid(v0), .rx_ready(rdy0),
        .frame_active(fa0), .overrun(ov0), .abort_seen(ab0));

    econet_rx_deframer #(.SYNC_STAGES(SYNC), .SUPPRESS_REPEAT_FLAGS(1'b1)) dut1 (
        .clock(clock), .reset(reset), .rx_enable(rx_enable),
        .econet_clock_R(econet_clock_R), .econet_data_R(econet_data_R),
        .rx_word(w1), .rx_valid(v1), .rx_ready(rdy1),
        .frame_active(fa1), .overrun(ov1), .abort_seen(ab1));

    always #20.833 clock = ~clock;

    typedef struct { logic [8:0] w; int due; } exp_t;
    exp_t       exp0[$], exp1[$];
    int         abq[$];
    logic [8:0] got0[$], got1[$];
    int         gotc1[$];
    logic [8:0] lit[8];

    int  vectors = 0, errs = 0;
    int  cyc = 0, rise_cyc = 0, ab_cnt1 = 0, tx_ones = 0;
    bit  checking = 0, strict = 1;

    int  m_ones = 0, m_nbits = 0;
    bit  m_frame = 0, m_lastflag = 0;
    logic [7:0] m_part = 8'd0;
    bit  fa_model = 0, fa_prev = 0;
    int  fa_due = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic void set_fa(input bit v, input int due);
        fa_prev  = fa_model;
        fa_model = v;
        fa_due   = due;
    endfunction

    function automatic void emit_w(input logic [8:0] w, input int due);
        exp_t e;
        e.w = w;
        e.due = due;
        exp0.push_back(e);
        if (!(w[8] && m_lastflag)) exp1.push_back(e);
        m_lastflag = w[8];
    endfunction

    // Line rules: six 1s then 0 is a flag, seven 1s an abort, five 1s then 0 a stuffed bit.
    function automatic void model_bit(input bit b, input int due);
        if (b && m_ones == 6) begin
            abq.push_back(due);
            m_ones = 7;
            m_nbits = 0;
            m_lastflag = 0;
            m_frame = 0;
            set_fa(0, due);
        end else if (!b && m_ones == 6) begin
            m_ones = 0;
            m_nbits = 0;
            m_frame = 1;
            set_fa(1, due);
            emit_w(9'h17E, due);
        end else begin
            if (m_frame && !(!b && m_ones == 5)) begin
                m_part[m_nbits[2:0]] = b;
                m_nbits++;
                if (m_nbits == 8) begin
                    emit_w({1'b0, m_part}, due);
                    m_nbits = 0;
                end
            end
            m_ones = b ? ((m_ones < 7) ? m_ones + 1 : 7) : 0;
        end
    endfunction

    function automatic void model_clear(input int due);
        m_ones = 0;
        m_nbits = 0;
        m_frame = 0;
        m_lastflag = 0;
        set_fa(0, due);
    endfunction

    always @(negedge clock) begin
        if (checking && !reset) begin
            bit h0, h1, ha, efa;
            h0 = (exp0.size() > 0) && (exp0[0].due == cyc);
            h1 = (exp1.size() > 0) && (exp1[0].due == cyc);
            ha = (abq.size() > 0) && (abq[0] == cyc);
            efa = (cyc >= fa_due) ? fa_model : fa_prev;
            chk("valid0", 32'(v0), 32'(h0));
            if (h0) chk("word0", 32'(w0), 32'(exp0[0].w));
            chk("overrun0", 32'(ov0), 32'd0);
            if (strict) begin
                chk("valid1", 32'(v1), 32'(h1));
                if (h1) chk("word1", 32'(w1), 32'(exp1[0].w));
                chk("overrun1", 32'(ov1), 32'd0);
            end
            chk("abort0", 32'(ab0), 32'(ha));
            chk("abort1", 32'(ab1), 32'(ha));
            chk("frame0", 32'(fa0), 32'(efa));
            chk("frame1", 32'(fa1), 32'(efa));
            if (h0) void'(exp0.pop_front());
            if (h1) void'(exp1.pop_front());
            if (ha) void'(abq.pop_front());
            if (v0) got0.push_back(w0);
            if (v1 && rdy1) begin
                got1.push_back(w1);
                gotc1.push_back(cyc);
            end
            if (ab1) ab_cnt1++;
        end
    end

    task automatic nedge(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic send_bit(input bit b);
        econet_data_R = b;
        nedge(48);
        econet_clock_R = 1'b1;
        rise_cyc = cyc;
        model_bit(b, cyc + SYNC + 2);
        nedge(24);
        econet_clock_R = 1'b0;
        nedge(48);
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) send_bit(f[i]);
        tx_ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
            tx_ones = b[i] ? tx_ones + 1 : 0;
            if (tx_ones == 5) begin
                send_bit(1'b0);
                tx_ones = 0;
            end
        end
    endtask

    task automatic send_raw(input bit b, input int n);
        for (int i = 0; i < n; i++) send_bit(b);
        tx_ones = 0;
    endtask

    task automatic check_seq(input string nm, input bit which, input int n);
        chk({nm, "_count"}, 32'(which ? got1.size() : got0.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [8:0] g;
            g = 9'h1FF;
            if (which && i < got1.size()) g = got1[i];
            if (!which && i < got0.size()) g = got0[i];
            chk($sformatf("%s_w%0d", nm, i), 32'(g), 32'(lit[i]));
        end
    endtask

    task automatic clear_got();
        got0.delete();
        got1.delete();
        gotc1.delete();
    endtask

    initial begin
        logic [7:0] b5a;
        int ab_base;
        b5a = 8'h5A;
        clock = 1'b0;
        reset = 1'b1;
        rx_enable = 1'b1;
        econet_clock_R = 1'b0;
        econet_data_R = 1'b1;
        rdy0 = 1'b1;
        rdy1 = 1'b1;
        #100;
        chk("rst_word", 32'(w1), 32'd0);
        chk("rst_valid", 32'(v1), 32'd0);
        chk("rst_frame", 32'(fa1), 32'd0);
        chk("rst_overrun", 32'(ov1), 32'd0);
        chk("rst_abort", 32'(ab1), 32'd0);
        nedge(2);
        reset = 1'b0;
        checking = 1'b1;

        // idle line: exactly one abort pulse
        ab_base = ab_cnt1;
        send_raw(1'b1, 8);
        chk("idle_abort_pulses", 32'(ab_cnt1 - ab_base), 32'd1);

        // byte-aligned frame with stuffing
        clear_got();
        send_flag();
        chk("latency", 32'((gotc1.size() > 0) ? gotc1[0] - rise_cyc : -1), 32'd4);
        chk("frame_after_flag", 32'(fa1), 32'd1);
        send_byte(8'h7E);
        send_byte(8'h42);
        send_byte(8'hFF);
        send_flag();
        lit = '{9'h17E, 9'h07E, 9'h042, 9'h0FF, 9'h17E, 9'h0, 9'h0, 9'h0};
        check_seq("t1_sup", 1'b1, 5);
        check_seq("t1_nosup", 1'b0, 5);
        send_raw(1'b1, 8);

        // repeated flags
        clear_got();
        send_flag();
        send_flag();
        send_flag();
        send_byte(8'h55);
        send_flag();
        lit = '{9'h17E, 9'h055, 9'h17E, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
        check_seq("rep_sup", 1'b1, 3);
        lit = '{9'h17E, 9'h17E, 9'h17E, 9'h055, 9'h17E, 9'h0, 9'h0, 9'h0};
        check_seq("rep_nosup", 1'b0, 5);
        send_raw(1'b1, 8);

        // abort mid-frame, then data in hunt is ignored
        clear_got();
        send_flag();
        send_byte(8'h42);
        ab_base = ab_cnt1;
        send_raw(1'b1, 8);
        chk("abort_pulses", 32'(ab_cnt1 - ab_base), 32'd1);
        chk("abort_frame", 32'(fa1), 32'd0);
        send_raw(1'b0, 8);
        lit = '{9'h17E, 9'h042, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
        check_seq("abort_sup", 1'b1, 2);

        // overrun with consumer stalled
        strict = 1'b0;
        rdy1 = 1'b0;
        send_flag();
        send_byte(8'h11);
        send_byte(8'h22);
        chk("ovr_word", 32'(w1), 32'h17E);
        chk("ovr_valid", 32'(v1), 32'd1);
        chk("ovr_flag", 32'(ov1), 32'd1);
        rdy1 = 1'b1;
        nedge(1);
        chk("ovr_drain_valid", 32'(v1), 32'd0);
        chk("ovr_sticky", 32'(ov1), 32'd1);
        rx_enable = 1'b0;
        model_clear(cyc + 1);
        nedge(2);
        rx_enable = 1'b1;
        chk("dis_overrun", 32'(ov1), 32'd0);
        chk("dis_frame", 32'(fa1), 32'd0);
        exp1.delete();
        strict = 1'b1;

        // asynchronous reset during the 4th bit of a byte
        strict = 1'b0;
        rdy1 = 1'b0;
        send_flag();
        send_byte(8'h33);
        for (int i = 0; i < 3; i++) send_bit(b5a[i]);
        econet_data_R = b5a[3];
        nedge(20);
        chk("prerst_valid", 32'(v1), 32'd1);
        chk("prerst_overrun", 32'(ov1), 32'd1);
        #5;
        reset = 1'b1;
        #1;
        chk("arst_word", 32'(w1), 32'd0);
        chk("arst_valid", 32'(v1), 32'd0);
        chk("arst_frame", 32'(fa1), 32'd0);
        chk("arst_overrun", 32'(ov1), 32'd0);
        chk("arst_abort", 32'(ab1), 32'd0);
        chk("arst_frame0", 32'(fa0), 32'd0);
        model_clear(cyc);
        fa_prev = 1'b0;
        exp0.delete();
        exp1.delete();
        nedge(3);
        reset = 1'b0;
        rdy1 = 1'b1;
        strict = 1'b1;
        for (int i = 3; i < 8; i++) send_bit(b5a[i]);
        clear_got();
        send_flag();
        send_byte(8'h77);
        send_flag();
        lit = '{9'h17E, 9'h077, 9'h17E, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
        check_seq("rst_sup", 1'b1, 3);

        nedge(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
